mod23_rr_sched: RTL and testbench
=================================

// Module: mod23_rr_sched
// PURPOSE
//  Shares one pipelined X-mod-23 residue datapath (registered X in, registered 5-bit R out)
//  among NREQ requesters. Round-robin arbitration issues at most one operand per cycle, tracks
//  in-flight requester IDs and returns results through a credit-protected response FIFO.
//  Sits between client blocks and the residue unit; the unit shares clk/rst_n with this block.
// PARAMETERS
//  NREQ      4   number of requesters (2..8)
//  XW        32  operand width
//  RW        5   residue width
//  LAT       2   cycles from dp_x driven to matching dp_r valid (input reg + output reg)
//  RSP_DEPTH 4   response FIFO entries; must be >= LAT+1
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  req_valid  in   NREQ       requester i has an operand
//  req_x      in   NREQ*XW    operand of requester i at bits [i*XW +: XW]
//  req_ready  out  NREQ       one-hot grant; transfer on req_valid[i] & req_ready[i]
//  dp_x       out  XW         operand to residue datapath
//  dp_r       in   RW         residue from datapath, LAT cycles after dp_x
//  rsp_valid  out  1          response FIFO non-empty
//  rsp_id     out  clog2(NREQ) requester index of head response
//  rsp_r      out  RW         residue of head response
//  rsp_ready  in   1          consumer pops head on rsp_valid & rsp_ready
//  busy       out  1          occupancy != 0
// BEHAVIOUR
//  - Reset (async): ptr=0, occupancy=0, ID/valid pipe cleared, FIFO empty; rsp_valid=0,
//    rsp_id=0, rsp_r=0, busy=0, req_ready=0, dp_x=0. Reset mid-operation discards all
//    in-flight and queued results; no stale response after release.
//  - Occupancy = operations issued and not yet popped (pipe + FIFO). Issue allowed only when
//    occupancy < RSP_DEPTH; a same-cycle pop is NOT counted (no rsp_ready->req_ready path).
//  - Arbitration (combinational): if issue allowed, grant first i with req_valid[i], searching
//    ptr, ptr+1, ... mod NREQ. req_ready is that one-hot grant, else all zero.
//    req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
//  - On grant of i: dp_x = req_x[i], else dp_x = 0. ptr <= (i+1) mod NREQ at the edge;
//    ptr unchanged if no grant.
//  - Tag pipe: LAT-stage shift of {valid, id}; stage LAT output aligns with dp_r.
//    When it is valid, {id, dp_r} is written to FIFO tail that edge.
//  - FIFO: in-order, show-ahead (rsp_* reflect head). Push and pop in same cycle both take
//    effect. Overflow impossible by credit rule; push to full is a design error (assert).
//  - occupancy: +1 on issue, -1 on pop, both in same cycle -> unchanged.
//  - Latency: grant in cycle t -> rsp_valid earliest cycle t+LAT (FIFO empty, 0 extra).
//  - Throughput: 1 op/cycle sustained with rsp_ready=1 given RSP_DEPTH >= LAT+1.
//  - Residue correctness belongs to the datapath; block passes dp_r unmodified.
// TESTING
//  1. req_valid=0100, req_x[2]=100 at t0 -> req_ready=0100 at t0; rsp_valid at t0+2,
//     rsp_id=2, rsp_r=8.
//  2. req_valid=1111 held, rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles;
//     responses in same order, 1/cycle.
//  3. rsp_ready=0, req_valid=0001 held -> exactly 4 grants, then req_ready=0, busy=1;
//     raise rsp_ready -> 4 pops in order, one new grant each cycle after occupancy drops.
//  4. Operands 0xFFFFFFFF, 22, 23, 0 from req 1 -> rsp_r = 11, 22, 0, 0 in order.
//  5. Two ops in flight + one queued, pulse rst_n low mid-cycle -> rsp_valid, busy,
//     req_ready go 0 immediately; after release no response for 5+ cycles without new req.
//  6. Occupancy=3, same cycle issue + pop -> occupancy stays 3; FIFO push and pop both
//     occur at one edge, order preserved.

Source files
------------

// File: rtl/mod23_rr_sched.sv
// Round-robin front end for a shared, pipelined X-mod-23 residue unit.
// Arbitrates requesters, tracks in-flight IDs alongside the datapath and
// returns {id, residue} through a credit-protected, fall-through response FIFO.
module mod23_rr_sched #(
    parameter int NREQ      = 4,
    parameter int XW        = 32,
    parameter int RW        = 5,
    parameter int LAT       = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*XW-1:0]       req_x,
    output logic [NREQ-1:0]          req_ready,
    output logic [XW-1:0]            dp_x,
    input  logic [RW-1:0]            dp_r,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [RW-1:0]            rsp_r,
    input  logic                     rsp_ready,
    output logic                     busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int OCW = $clog2(RSP_DEPTH + 1);
    localparam int PW  = $clog2(RSP_DEPTH);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [RW-1:0]  r;
    } rsp_t;

    logic [NREQ-1:0][XW-1:0] req_x_a;
    logic [IDW-1:0]          ptr;
    logic [OCW-1:0]          occ;
    logic                    issue_ok;
    logic [NREQ-1:0]         gnt;
    logic [IDW-1:0]          gnt_id;
    logic                    found;
    logic [IDW:0]            idx;
    logic                    issue;
    logic [LAT:1]            vld_pipe;
    logic [LAT:1][IDW-1:0]   id_pipe;
    rsp_t                    mem [RSP_DEPTH];
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [OCW-1:0]          fifo_cnt;
    logic                    fifo_empty;
    rsp_t                    in_rsp, head;
    logic                    pop, push, fifo_pop;

    assign req_x_a = req_x;

    // Credit check deliberately ignores a same-cycle pop so req_ready never
    // depends on rsp_ready; grants are also held off while reset is asserted.
    assign issue_ok = rst_n && (occ < OCW'(RSP_DEPTH));

    // Round-robin search starting at ptr; first valid requester wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ))
                idx = idx - (IDW+1)'(NREQ);
            if (!found && issue_ok && req_valid[idx[IDW-1:0]]) begin
                found            = 1'b1;
                gnt[idx[IDW-1:0]] = 1'b1;
                gnt_id           = idx[IDW-1:0];
            end
        end
    end

    assign issue     = found;
    assign req_ready = gnt;
    assign dp_x      = issue ? req_x_a[gnt_id] : '0;

    // Pointer moves just past the winner; stays put on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (issue)
            ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
    end

    // Tag pipe mirrors the datapath latency so stage LAT lines up with dp_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[1] <= issue;
            id_pipe[1]  <= gnt_id;
            for (int s = 2; s <= LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
        end
    end

    // Fall-through FIFO: when empty, the arriving result is presented directly
    // so an idle block adds no latency beyond the datapath's own.
    assign in_rsp     = '{id: id_pipe[LAT], r: dp_r};
    assign fifo_empty = (fifo_cnt == '0);
    assign head       = fifo_empty ? in_rsp : mem[rd_ptr];
    assign rsp_valid  = !fifo_empty || vld_pipe[LAT];
    assign rsp_id     = rsp_valid ? head.id : '0;
    assign rsp_r      = rsp_valid ? head.r  : '0;
    assign pop        = rsp_valid && rsp_ready;
    assign push       = vld_pipe[LAT] && !(fifo_empty && rsp_ready);
    assign fifo_pop   = pop && !fifo_empty;

    // Storage array carries no reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_rsp;
    end

    // FIFO pointers and fill count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PW'(RSP_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            if (fifo_pop)
                rd_ptr <= (rd_ptr == PW'(RSP_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            case ({push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Occupancy counts everything issued and not yet popped (pipe + FIFO).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            occ <= '0;
        else
            case ({issue, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
    end

    assign busy = (occ != '0);

    // Credit scheme guarantees the FIFO never receives a push while full.
    assert property (@(posedge clk) disable iff (!rst_n)
                     !(push && fifo_cnt == OCW'(RSP_DEPTH)));

endmodule

// File: tb/tb_mod23_rr_sched.sv
// Directed bench for mod23_rr_sched with a behavioural 2-stage residue unit.
module tb_mod23_rr_sched;
    logic         clk, rst_n;
    logic [3:0]   req_valid, req_ready;
    logic [127:0] req_x;
    logic [31:0]  dp_x;
    logic [4:0]   dp_r;
    logic         rsp_valid, rsp_ready, busy;
    logic [1:0]   rsp_id;
    logic [4:0]   rsp_r;

    int npass = 0;
    int ntot  = 0;

    mod23_rr_sched #(.NREQ(4), .XW(32), .RW(5), .LAT(2), .RSP_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x),
        .req_ready(req_ready), .dp_x(dp_x), .dp_r(dp_r), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_r(rsp_r), .rsp_ready(rsp_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Residue unit model: input register then output register.
    logic [31:0] x_q;
    logic [4:0]  r_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            r_q <= '0;
        end else begin
            x_q <= dp_x;
            r_q <= 5'(x_q % 32'd23);
        end
    end
    assign dp_r = r_q;

    typedef struct {
        logic [3:0] rv;
        logic       rr;
        logic [3:0] rdy;
        logic       rsv;
        logic [1:0] id;
        logic [4:0] r;
        logic       bsy;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_x(input int i, input logic [31:0] v);
        req_x[i*32 +: 32] = v;
    endtask

    // Leaves the bench at posedge+1 of the first cycle after release.
    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int grants;
        logic [31:0] ops [4];
        logic [4:0]  exp4 [4];
        logic [3:0]  rdy3 [5];
        logic [4:0]  r3 [5];

        // round robin, all requesting, responses one per cycle
        tbl[0] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 5'd0,  1'b0};
        tbl[1] = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, 5'd0,  1'b1};
        tbl[2] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd0, 5'd8,  1'b1};
        tbl[3] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd1, 5'd9,  1'b1};
        tbl[4] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd2, 5'd10, 1'b1};
        tbl[5] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd3, 5'd11, 1'b1};
        tbl[6] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 5'd8,  1'b1};
        tbl[7] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 5'd9,  1'b1};
        tbl[8] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 5'd0,  1'b0};

        ops  = '{32'hFFFF_FFFF, 32'd22, 32'd23, 32'd0};
        exp4 = '{5'd11, 5'd22, 5'd0, 5'd0};
        rdy3 = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        r3   = '{5'd16, 5'd17, 5'd18, 5'd19, 5'd20};

        // reset state, with requests pending so gating is visible
        rst_n = 1'b0; rsp_ready = 1'b0; req_valid = '0;
        req_x = {4{32'd55}};
        #3 req_valid = 4'b1111;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_dp_x", dp_x, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_r", 32'(rsp_r), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // single request, minimum latency
        do_reset();
        set_x(2, 32'd100);
        rsp_ready = 1'b1; req_valid = 4'b0100;
        #1;
        chk("t1_ready", 32'(req_ready), 32'b0100);
        chk("t1_dp_x", dp_x, 32'd100);
        tick(); req_valid = '0; #1;
        chk("t1_c1_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t1_c1_busy", 32'(busy), 32'd1);
        tick(); #1;
        chk("t1_c2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_c2_rsp_id", 32'(rsp_id), 32'd2);
        chk("t1_c2_rsp_r", 32'(rsp_r), 32'd8);
        tick(); #1;
        chk("t1_c3_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t1_c3_busy", 32'(busy), 32'd0);

        // table: round-robin sweep
        do_reset();
        for (int i = 0; i < 4; i++) set_x(i, 32'(100 + i));
        for (int i = 0; i < 9; i++) begin
            req_valid = tbl[i].rv;
            rsp_ready = tbl[i].rr;
            #1;
            chk($sformatf("t2_%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
            chk($sformatf("t2_%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].rsv));
            if (tbl[i].rsv) begin
                chk($sformatf("t2_%0d_rsp_id", i), 32'(rsp_id), 32'(tbl[i].id));
                chk($sformatf("t2_%0d_rsp_r", i), 32'(rsp_r), 32'(tbl[i].r));
            end
            chk($sformatf("t2_%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
            tick();
        end

        // credit limit with stalled consumer, then release
        do_reset();
        rsp_ready = 1'b0; req_valid = 4'b0001; grants = 0;
        for (int k = 0; k < 6; k++) begin
            set_x(0, 32'(200 + k));
            #1;
            if (req_ready[0]) grants++;
            if (k >= 4) begin
                chk($sformatf("t3_stall%0d_ready", k), 32'(req_ready), 32'd0);
                chk($sformatf("t3_stall%0d_busy", k), 32'(busy), 32'd1);
            end
            tick();
        end
        chk("t3_grant_count", 32'(grants), 32'd4);
        rsp_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            set_x(0, 32'(203 + j));
            #1;
            chk($sformatf("t3_p%0d_ready", j), 32'(req_ready), 32'(rdy3[j]));
            chk($sformatf("t3_p%0d_rsp_valid", j), 32'(rsp_valid), 32'd1);
            chk($sformatf("t3_p%0d_rsp_r", j), 32'(rsp_r), 32'(r3[j]));
            if (j >= 1)
                chk($sformatf("t6_p%0d_occ", j), 32'(dut.occ), 32'd3);
            tick();
        end
        req_valid = '0;
        repeat (5) tick();
        chk("t3_drain_busy", 32'(busy), 32'd0);
        chk("t3_drain_rsp_valid", 32'(rsp_valid), 32'd0);

        // boundary operands
        do_reset();
        rsp_ready = 1'b1; req_valid = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) set_x(1, ops[k]);
            else req_valid = '0;
            #1;
            if (k >= 2) begin
                chk($sformatf("t4_%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
                chk($sformatf("t4_%0d_rsp_id", k), 32'(rsp_id), 32'd1);
                chk($sformatf("t4_%0d_rsp_r", k), 32'(rsp_r), 32'(exp4[k-2]));
            end
            tick();
        end

        // reset mid-operation discards in-flight and queued results
        do_reset();
        rsp_ready = 1'b0; req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            set_x(0, 32'(50 + k));
            tick();
        end
        #1;
        chk("t5_pre_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t5_pre_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ready", 32'(req_ready), 32'd0);
        chk("t5_rst_dp_x", dp_x, 32'd0);
        @(posedge clk);
        #3;
        req_valid = '0; rsp_ready = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("t5_post%0d_rsp_valid", k), 32'(rsp_valid), 32'd0);
            chk($sformatf("t5_post%0d_busy", k), 32'(busy), 32'd0);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
